ddr2_client_port: RTL

//  Synthesizable initiator for the DDR2 controller client interface (c_addr/c_data_in/c_rd_req/c_wr_req ->
//  c_ack/c_rdy/c_data_out). Accepts read/write commands on a valid/ready bus and queues them in a FIFO.

---
 rtl/ddr2_client_port.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ddr2_client_port.sv
// Command-queueing initiator for the DDR2 controller client req/ack/rdy interface.
// Define DDR2_CLIENT_READBACK_EN to verify every successful write with a read of the same address.
module ddr2_client_port #(
    parameter int ADDR_W     = 26,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    output logic              c_rd_req,
    output logic              c_wr_req,
    input  logic              c_ack,
    input  logic              c_rdy,
    input  logic [DATA_W-1:0] c_data_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
`ifdef DDR2_CLIENT_READBACK_EN
        ,
        S_RB_REQ,
        S_RB_WAIT
`endif
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty;
    logic             push, pop;
    cmd_t             head;

    assign fifo_empty = (fifo_count == '0);
    assign req_ready  = (fifo_count != (PTR_W+1)'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    assign head       = fifo_mem[rd_ptr];

    // NOTE: storage has no reset; only the pointers and count define FIFO contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    state_t            state, state_n;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              c_rdy_q, rdy_rise, timeout;
    logic              in_req, in_wait, complete;
    logic              cur_we, cur_we_n;
    logic              c_rd_req_n, c_wr_req_n;
    logic [ADDR_W-1:0] c_addr_n;
    logic [DATA_W-1:0] c_data_in_n, rsp_rdata_n;
    logic              rsp_we_n, rsp_err_n;

    assign rdy_rise  = c_rdy && !c_rdy_q;
    assign timeout   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
    assign rsp_valid = (state == S_RESP);
    assign busy      = !fifo_empty || (state != S_IDLE);

`ifdef DDR2_CLIENT_READBACK_EN
    logic in_rb;
    assign in_rb   = (state == S_RB_REQ) || (state == S_RB_WAIT);
    assign in_req  = (state == S_REQ)  || (state == S_RB_REQ);
    assign in_wait = (state == S_WAIT) || (state == S_RB_WAIT);
`else
    assign in_req  = (state == S_REQ);
    assign in_wait = (state == S_WAIT);
`endif

    // Completion may arrive together with c_ack, skipping the wait phase.
    assign complete = rdy_rise && ((in_req && c_ack) || in_wait);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tmo_cnt   <= '0;
            c_rdy_q   <= 1'b0;
            cur_we    <= 1'b0;
            c_rd_req  <= 1'b0;
            c_wr_req  <= 1'b0;
            c_addr    <= '0;
            c_data_in <= '0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            tmo_cnt   <= (state_n != state) ? '0 : tmo_cnt + 1'b1;
            c_rdy_q   <= c_rdy;
            cur_we    <= cur_we_n;
            c_rd_req  <= c_rd_req_n;
            c_wr_req  <= c_wr_req_n;
            c_addr    <= c_addr_n;
            c_data_in <= c_data_in_n;
            rsp_we    <= rsp_we_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_n     = state;
        pop         = 1'b0;
        cur_we_n    = cur_we;
        c_rd_req_n  = c_rd_req;
        c_wr_req_n  = c_wr_req;
        c_addr_n    = c_addr;
        c_data_in_n = c_data_in;
        rsp_we_n    = rsp_we;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;

        case (state)
            S_IDLE: begin
                if (!fifo_empty && c_rdy) begin
                    pop         = 1'b1;
                    cur_we_n    = head.we;
                    c_addr_n    = head.addr;
                    c_data_in_n = head.wdata;
                    c_wr_req_n  = head.we;
                    c_rd_req_n  = !head.we;
                    state_n     = S_REQ;
                end
            end
            S_RESP: state_n = S_IDLE;
            default: begin
                if (in_req && (c_ack || timeout)) begin
                    c_rd_req_n = 1'b0;
                    c_wr_req_n = 1'b0;
                end
                if (complete) begin
                    rsp_we_n  = cur_we;
                    rsp_err_n = 1'b0;
                    state_n   = S_RESP;
`ifdef DDR2_CLIENT_READBACK_EN
                    if (in_rb) begin
                        rsp_rdata_n = c_data_out;
                        rsp_err_n   = (c_data_out != c_data_in);
                    end else if (cur_we) begin
                        // c_rdy is high here, so the readback launches immediately.
                        c_rd_req_n = 1'b1;
                        state_n    = S_RB_REQ;
                    end else begin
                        rsp_rdata_n = c_data_out;
                    end
`else
                    rsp_rdata_n = cur_we ? '0 : c_data_out;
`endif
                end else if (in_req && c_ack) begin
`ifdef DDR2_CLIENT_READBACK_EN
                    state_n = in_rb ? S_RB_WAIT : S_WAIT;
`else
                    state_n = S_WAIT;
`endif
                end else if (timeout) begin
                    rsp_we_n    = cur_we;
                    rsp_rdata_n = '0;
                    rsp_err_n   = 1'b1;
                    state_n     = S_RESP;
                end
            end
        endcase
    end

endmodule
